icache_line_loader: RTL and testbench

Fill engine on the write side of the 512-entry by 512-bit instruction-cache line store.
- Accepts one miss request at a time.
- Fetches the 64-byte line from memory as four 128-bit bus beats, critical beat first with wrap-around.
- Assembles the beats into an ICacheLine.
- Issues a single-cycle write of line data plus tag into the cache arrays.

---
 rtl/rfPhoenixPkg.sv | 21 ++
 rtl/icache_line_loader.sv | 142 ++++++++++++++
 tb/tb_icache_line_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rfPhoenixPkg.sv
// rtl/rfPhoenixPkg.sv - shared rfPhoenix types: instruction-cache line, tag, fill-engine states
package rfPhoenixPkg;

  localparam int ICACHE_ADR_W = 32;
  localparam int ICACHE_BEATS = 4;
  localparam int ICACHE_IDX_W = 9;

  // One 64-byte instruction-cache line; beat slot k occupies bits [128k+127:128k].
  typedef logic [511:0] ICacheLine;

  // Address bits above the 9-bit index and 6-bit line offset.
  typedef logic [ICACHE_ADR_W-16:0] ICacheTag;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    ABORT
  } icl_state_t;

endpackage

// File: rtl/icache_line_loader.sv
// rtl/icache_line_loader.sv - icache line fill engine: 4-beat critical-first fetch, one-cycle line-store write
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   miss_req/miss_adr miss request and byte address, sampled only while idle
//   busy              engine not idle
//   cyc_o/stb_o/adr_o bus cycle, strobe and 16-byte aligned beat address
//   ack_i/err_i/dat_i bus beat accept, bus error, 128-bit beat data
//   wr/wadr/line_o    line-store write strobe, index and line data
//   tag_o             tag written alongside the line
//   done/err          one-cycle pulses: line written / fetch aborted
module icache_line_loader
  import rfPhoenixPkg::*;
#(
  parameter int ADR_W = 32,
  parameter int BEATS = 4,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_req,
  input  logic [ADR_W-1:0] miss_adr,
  output logic             busy,
  output logic             cyc_o,
  output logic             stb_o,
  output logic [ADR_W-1:0] adr_o,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic [127:0]     dat_i,
  output logic             wr,
  output logic [8:0]       wadr,
  output ICacheLine        line_o,
  output logic [ADR_W-16:0] tag_o,
  output logic             done,
  output logic             err
);

  localparam int TMO_W = $clog2(TMO + 1);

  icl_state_t          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0]          first_q, first_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ADR_W-7:0]    base_q, base_d;
  ICacheLine           line_q, line_d;
  ICacheLine           line_out_q, line_out_d;
  logic [8:0]          wadr_q, wadr_d;
  logic [ADR_W-16:0]   tag_q, tag_d;
  logic [1:0]          slot;

  // Beat offsets are below the line boundary, so nothing ever carries into bit 6.
  logic unused_adr_bits;
  assign unused_adr_bits = ^miss_adr[3:0];

  // 2-bit add wraps the critical-first order around the line.
  assign slot = first_q + cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      first_q    <= '0;
      tmo_q      <= '0;
      base_q     <= '0;
      line_q     <= '0;
      line_out_q <= '0;
      wadr_q     <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      tmo_q      <= tmo_d;
      base_q     <= base_d;
      line_q     <= line_d;
      line_out_q <= line_out_d;
      wadr_q     <= wadr_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    tmo_d      = tmo_q;
    base_d     = base_q;
    line_d     = line_q;
    line_out_d = line_out_q;
    wadr_d     = wadr_q;
    tag_d      = tag_q;
    case (state_q)
      IDLE: begin
        if (miss_req) begin
          base_d  = miss_adr[ADR_W-1:6];
          first_d = miss_adr[5:4];
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (err_i) begin
          state_d = ABORT;
        end else if (ack_i) begin
          line_d[{slot, 7'b0} +: 128] = dat_i;
          tmo_d = '0;
          if (cnt_q == 2'(BEATS - 1)) begin
            // Output registers load only here so they hold steady outside WRITE.
            line_out_d = line_d;
            wadr_d     = base_q[8:0];
            tag_d      = base_q[ADR_W-7:9];
            state_d    = WRITE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TMO)) begin
            state_d = ABORT;
          end
        end
      end
      WRITE:   state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decode straight from the state register, so reset clears them immediately.
  assign busy   = (state_q != IDLE);
  assign cyc_o  = (state_q == FETCH);
  assign stb_o  = (state_q == FETCH);
  assign adr_o  = cyc_o ? {base_q, slot, 4'b0} : '0;
  assign wr     = (state_q == WRITE);
  assign done   = (state_q == WRITE);
  assign err    = (state_q == ABORT);
  assign wadr   = wadr_q;
  assign line_o = line_out_q;
  assign tag_o  = tag_q;

endmodule

// File: tb/tb_icache_line_loader.sv
// tb/tb_icache_line_loader.sv - self-checking bench for icache_line_loader
module tb_icache_line_loader;

  localparam int ADR_W = 32;
  localparam int TMO   = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             miss_req;
  logic [ADR_W-1:0] miss_adr;
  logic             busy, cyc_o, stb_o, ack_i, err_i, wr, done, err;
  logic [ADR_W-1:0] adr_o;
  logic [127:0]     dat_i;
  logic [8:0]       wadr;
  logic [511:0]     line_o;
  logic [ADR_W-16:0] tag_o;

  always #5 clk = ~clk;

  icache_line_loader #(.ADR_W(ADR_W), .BEATS(4), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_adr(miss_adr),
    .busy(busy), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o),
    .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .wr(wr), .wadr(wadr), .line_o(line_o), .tag_o(tag_o),
    .done(done), .err(err)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] seed;

  logic [31:0]  obs_adr[$];
  int           obs_wr_cnt, obs_wr_cyc, obs_done_cyc, obs_err_cyc, obs_idle_cyc;
  bit           obs_timeout;
  logic [511:0] obs_line;
  logic [8:0]   obs_wadr;
  logic [16:0]  obs_tag;

  // Memory contents: any address-dependent pattern the bench can recompute.
  function automatic logic [127:0] mem(input logic [31:0] a);
    return {a, a ^ seed, ~a, a + seed};
  endfunction

  function automatic logic [511:0] exp_line(input logic [31:0] adr);
    logic [31:0]  base;
    logic [511:0] l;
    base = adr & 32'hFFFF_FFC0;
    for (int k = 0; k < 4; k++) l[128*k +: 128] = mem(base + 32'(16 * k));
    return l;
  endfunction

  function automatic logic [31:0] exp_adr(input logic [31:0] adr, input int i);
    int first;
    first = int'((adr >> 4) & 32'd3);
    return (adr & 32'hFFFF_FFC0) + 32'(((first + i) % 4) * 16);
  endfunction

  // Drives one miss as requester and bus slave; records what the DUT did.
  task automatic do_fetch(input logic [31:0] adr, input int waits, input int err_beat,
                          input bit no_ack, input bit beat_num_data, input bit chg_adr);
    int waitcnt = 0;
    int beat = 0;
    obs_adr.delete();
    obs_wr_cnt = 0; obs_wr_cyc = -1; obs_done_cyc = -1; obs_err_cyc = -1;
    obs_idle_cyc = -1; obs_timeout = 1'b0;
    miss_req = 1'b1;
    miss_adr = adr;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (chg_adr && c == 2) miss_adr = adr ^ 32'h0055_5540;
      if (wr) begin
        obs_wr_cnt++; obs_wr_cyc = c;
        obs_line = line_o; obs_wadr = wadr; obs_tag = tag_o;
      end
      if (done) obs_done_cyc = c;
      if (err) obs_err_cyc = c;
      ack_i = 1'b0; err_i = 1'b0;
      if (!busy) begin
        obs_idle_cyc = c;
        break;
      end
      if (done || err) miss_req = 1'b0;
      if (cyc_o && stb_o && !no_ack) begin
        if (waitcnt < waits) waitcnt++;
        else begin
          waitcnt = 0;
          ack_i = 1'b1;
          dat_i = beat_num_data ? 128'(beat) : mem(adr_o);
          err_i = (beat == err_beat);
          obs_adr.push_back(adr_o);
          beat++;
        end
      end
    end
    if (obs_idle_cyc < 0) obs_timeout = 1'b1;
    miss_req = 1'b0; ack_i = 1'b0; err_i = 1'b0;
  endtask

  task automatic check_normal(input string nm, input logic [31:0] adr, input int exp_wr_cyc);
    checks++;
    if (obs_timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout engine never returned idle", nm); end
    checks++;
    if (obs_adr.size() !== 4) begin errors++; $display("FAIL %s_beats got=%0d exp=4", nm, obs_adr.size()); end
    for (int i = 0; i < 4 && i < obs_adr.size(); i++) begin
      checks++;
      if (obs_adr[i] !== exp_adr(adr, i)) begin
        errors++; $display("FAIL %s_adr%0d got=%h exp=%h", nm, i, obs_adr[i], exp_adr(adr, i));
      end
    end
    checks++;
    if (obs_wr_cnt !== 1 || obs_wr_cyc !== exp_wr_cyc || obs_done_cyc !== exp_wr_cyc) begin
      errors++; $display("FAIL %s_wr_timing wr_cnt=%0d wr_cyc=%0d done_cyc=%0d exp_cyc=%0d",
                         nm, obs_wr_cnt, obs_wr_cyc, obs_done_cyc, exp_wr_cyc);
    end
    checks++;
    if (obs_idle_cyc !== exp_wr_cyc + 1) begin
      errors++; $display("FAIL %s_idle got=%0d exp=%0d", nm, obs_idle_cyc, exp_wr_cyc + 1);
    end
    checks++;
    if (obs_wadr !== adr[14:6] || obs_tag !== adr[31:15]) begin
      errors++; $display("FAIL %s_wadr_tag got=%h/%h exp=%h/%h", nm, obs_wadr, obs_tag, adr[14:6], adr[31:15]);
    end
    checks++;
    if (obs_err_cyc !== -1) begin errors++; $display("FAIL %s_spurious_err cyc=%0d", nm, obs_err_cyc); end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, cyc_o, stb_o, wr, done, err} !== 6'b0 || adr_o !== '0 || line_o !== '0 ||
        wadr !== '0 || tag_o !== '0) begin
      errors++; $display("FAIL reset_outputs busy=%b cyc=%b wr=%b adr=%h wadr=%h tag=%h",
                         busy, cyc_o, wr, adr_o, wadr, tag_o);
    end
  endtask

  task automatic test_aligned;
    do_fetch(32'h0001_2340, 0, -1, 1'b0, 1'b1, 1'b0);
    check_normal("aligned", 32'h0001_2340, 5);
    checks++;
    if (obs_line !== {128'd3, 128'd2, 128'd1, 128'd0}) begin
      errors++; $display("FAIL aligned_line got=%h exp=slots 0,1,2,3", obs_line);
    end
    checks++;
    if (obs_wadr !== 9'h08D) begin errors++; $display("FAIL aligned_wadr got=%h exp=08d", obs_wadr); end
  endtask

  task automatic test_wrap;
    do_fetch(32'h0001_2378, 0, -1, 1'b0, 1'b0, 1'b0);
    check_normal("wrap", 32'h0001_2378, 5);
    checks++;
    if (obs_line !== exp_line(32'h0001_2378)) begin
      errors++; $display("FAIL wrap_line got=%h exp=%h", obs_line, exp_line(32'h0001_2378));
    end
  endtask

  task automatic test_wait_states;
    do_fetch(32'h0001_2360, 2, -1, 1'b0, 1'b0, 1'b0);
    check_normal("wait2", 32'h0001_2360, 13);
    checks++;
    if (obs_line !== exp_line(32'h0001_2360)) begin
      errors++; $display("FAIL wait2_line got=%h exp=%h", obs_line, exp_line(32'h0001_2360));
    end
  endtask

  task automatic test_bus_error;
    do_fetch(32'h0002_0010, 0, 2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_err_cyc !== 4 || obs_wr_cnt !== 0 || obs_done_cyc !== -1 || obs_idle_cyc !== 5) begin
      errors++; $display("FAIL buserr err_cyc=%0d wr_cnt=%0d done_cyc=%0d idle=%0d exp=4/0/-1/5",
                         obs_err_cyc, obs_wr_cnt, obs_done_cyc, obs_idle_cyc);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] a;
    do_fetch(32'h0003_0000, 0, -1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_err_cyc !== TMO + 1 || obs_wr_cnt !== 0 || obs_idle_cyc !== TMO + 2) begin
      errors++; $display("FAIL timeout err_cyc=%0d wr_cnt=%0d idle=%0d exp=%0d/0/%0d",
                         obs_err_cyc, obs_wr_cnt, obs_idle_cyc, TMO + 1, TMO + 2);
    end
    a = $urandom;
    do_fetch(a, 1, -1, 1'b0, 1'b0, 1'b1);
    check_normal("after_tmo", a, 9);
    checks++;
    if (obs_line !== exp_line(a)) begin
      errors++; $display("FAIL after_tmo_line got=%h exp=%h", obs_line, exp_line(a));
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    int w;
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      w = int'($urandom_range(0, 3));
      do_fetch(a, w, -1, 1'b0, 1'b0, 1'b0);
      check_normal("rand", a, 4 * (w + 1) + 1);
      checks++;
      if (obs_line !== exp_line(a)) begin
        errors++; $display("FAIL rand_line n=%0d got=%h exp=%h", n, obs_line, exp_line(a));
      end
    end
  endtask

  task automatic test_reset_mid;
    int beat = 0;
    logic [31:0] a;
    miss_req = 1'b1;
    miss_adr = 32'h0004_5670;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ack_i = 1'b0;
      if (beat == 2) break;
      if (cyc_o) begin
        ack_i = 1'b1; dat_i = mem(adr_o); beat++;
      end
    end
    miss_req = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, cyc_o, stb_o, wr, done, err} !== 6'b0 || adr_o !== '0 || line_o !== '0) begin
      errors++; $display("FAIL rst_mid_async busy=%b cyc=%b stb=%b wr=%b adr=%h",
                         busy, cyc_o, stb_o, wr, adr_o);
    end
    @(posedge clk); #1;
    checks++;
    if (wr !== 1'b0 || cyc_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_hold wr=%b cyc=%b exp=0/0", wr, cyc_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a = $urandom;
    do_fetch(a, 0, -1, 1'b0, 1'b0, 1'b0);
    check_normal("after_rst", a, 5);
    checks++;
    if (obs_line !== exp_line(a)) begin
      errors++; $display("FAIL after_rst_line got=%h exp=%h", obs_line, exp_line(a));
    end
  endtask

  initial begin
    seed = $urandom;
    rst = 1'b0; miss_req = 1'b0; miss_adr = '0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_aligned;
    test_wrap;
    test_wait_states;
    test_bus_error;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
